// File: rtl/bitperm_pkg.sv
// Shared definitions for the bit-permutation pipeline.
//
// Contents:
//   bp_mode_e - runtime permutation select carried on in_mode
//   BP_CNT_W  - width of the optional output-transfer counter
package bitperm_pkg;

  typedef enum logic [1:0] {
    BP_PASS     = 2'd0,
    BP_REV      = 2'd1,
    BP_ROTL     = 2'd2,
    BP_PAIRSWAP = 2'd3
  } bp_mode_e;

  localparam int BP_CNT_W = 16;

endpackage

// File: rtl/bitperm_core.sv
// Purely combinational WIDTH-bit permutation network.
//
// Ports:
//   data  in  WIDTH  word to permute
//   mode  in  2      bp_mode_e permutation select
//   amt   in  AW     rotate-left amount, only used by BP_ROTL (taken mod WIDTH)
//   perm  out WIDTH  permuted word
module bitperm_core
  import bitperm_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  bp_mode_e         mode,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] perm
);

  int rot;
  int src;

  always_comb begin
    perm = data;
    rot  = 0;
    src  = 0;
    case (mode)
      BP_PASS: perm = data;
      BP_REV: begin
        for (int i = 0; i < WIDTH; i++) perm[i] = data[WIDTH-1-i];
      end
      BP_ROTL: begin
        // amt can reach 2**AW-1, which exceeds WIDTH-1 when WIDTH is not a
        // power of two, so reduce it first.
        rot = int'(amt) % WIDTH;
        for (int i = 0; i < WIDTH; i++) begin
          src     = (i + WIDTH - rot) % WIDTH;
          perm[i] = data[src];
        end
      end
      BP_PAIRSWAP: begin
        // An odd MSB has no partner and keeps the default perm = data.
        for (int k = 0; k + 1 < WIDTH; k += 2) begin
          perm[k]   = data[k+1];
          perm[k+1] = data[k];
        end
      end
      default: perm = data;
    endcase
  end

endmodule

// File: rtl/bitperm_pipe.sv
// Pipelined bit-permutation register: permutes the input word with
// bitperm_core and carries it through STAGES valid/data register stages.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. Valid never waits for ready; in_ready is
// combinational from out_ready through the stage-advance chain.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   in_valid     in   input word present
//   in_ready     out  input word accepted this cycle
//   in_data      in   WIDTH input word
//   in_mode      in   2-bit permutation select (bp_mode_e), sampled with data
//   in_amt       in   AW rotate amount (BP_ROTL only)
//   out_valid    out  output word present
//   out_ready    in   downstream accepts the word
//   out_data     out  WIDTH permuted word
//   out_count    out  16-bit saturating count of output transfers, present
//                     only when BITPERM_PIPE_COUNT_EN is defined
module bitperm_pipe
  import bitperm_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [1:0]          in_mode,
  input  logic [AW-1:0]       in_amt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data
`ifdef BITPERM_PIPE_COUNT_EN
  ,
  output logic [BP_CNT_W-1:0] out_count
`endif
);

  logic [WIDTH-1:0]  perm;
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES-1:0] adv;
  logic              adv_acc;

  bitperm_core #(.WIDTH(WIDTH)) u_core (
    .data (in_data),
    .mode (bp_mode_e'(in_mode)),
    .amt  (in_amt),
    .perm (perm)
  );

  // adv[s] = out_ready || any bubble at or downstream of stage s. Written as
  // an OR-reduction per stage rather than a chain on adv itself, so the
  // logic has no self-referencing vector.
  always_comb begin
    adv     = '0;
    adv_acc = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      adv_acc = out_ready;
      for (int t = s; t < STAGES; t++) adv_acc = adv_acc | ~v[t];
      adv[s] = adv_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int s = 0; s < STAGES; s++) d[s] <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= in_valid;
        d[0] <= perm;
      end
      for (int s = 1; s < STAGES; s++) begin
        if (adv[s]) begin
          v[s] <= v[s-1];
          d[s] <= d[s-1];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

`ifdef BITPERM_PIPE_COUNT_EN
  logic [BP_CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (out_valid && out_ready && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_bitperm_pipe.sv
// Directed testbench for bitperm_pipe. Main instance WIDTH=8 STAGES=2, plus
// a WIDTH=2 STAGES=1 instance (REV) and a WIDTH=6 STAGES=2 instance (ROTL
// with amount wrap). Define BITPERM_PIPE_COUNT_EN to also cover out_count.
module tb_bitperm_pipe;

  logic       clk = 1'b0;
  logic       reset;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [1:0] in_mode;
  logic [2:0] in_amt;

  logic       in_valid2, in_ready2, out_valid2, out_ready2;
  logic [1:0] in_data2, out_data2;
  logic [1:0] in_mode2;
  logic [0:0] in_amt2;

  logic       in_valid6, in_ready6, out_valid6, out_ready6;
  logic [5:0] in_data6, out_data6;
  logic [1:0] in_mode6;
  logic [2:0] in_amt6;

`ifdef BITPERM_PIPE_COUNT_EN
  logic [15:0] count8, count2, count6;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  bitperm_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef BITPERM_PIPE_COUNT_EN
    , .out_count(count8)
`endif
  );

  bitperm_pipe #(.WIDTH(2), .STAGES(1)) u_dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .in_mode(in_mode2), .in_amt(in_amt2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
`ifdef BITPERM_PIPE_COUNT_EN
    , .out_count(count2)
`endif
  );

  bitperm_pipe #(.WIDTH(6), .STAGES(2)) u_dut6 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
    .in_mode(in_mode6), .in_amt(in_amt6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6)
`ifdef BITPERM_PIPE_COUNT_EN
    , .out_count(count6)
`endif
  );

  // Advance to just after the next rising edge; all driving and sampling
  // happens here, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    in_valid   = 1'b1;   // offered during reset, must be discarded
    in_data    = 8'hFF;
    in_mode    = 2'd0;
    in_amt     = '0;
    out_ready  = 1'b0;
    in_valid2  = 1'b0; in_data2 = '0; in_mode2 = '0; in_amt2 = '0; out_ready2 = 1'b1;
    in_valid6  = 1'b0; in_data6 = '0; in_mode6 = '0; in_amt6 = '0; out_ready6 = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", out_data);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid2 !== 1'b0 || out_valid6 !== 1'b0)
      $display("FAIL reset_small_valid got=%b%b exp=00", out_valid2, out_valid6);
    else n_pass++;
`ifdef BITPERM_PIPE_COUNT_EN
    n_checks++;
    if (count8 !== 16'd0) $display("FAIL reset_count got=%0d exp=0", count8);
    else n_pass++;
`endif
    reset    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_discard got=%b exp=0", out_valid);
    else n_pass++;
  endtask

  // One word through an empty W=8 pipe: accepted at edge N, not yet out
  // after N, visible after N+1 (two cycles after it was presented).
  task automatic test_mode8(input string name, input logic [7:0] data,
                            input logic [1:0] mode, input logic [2:0] amt,
                            input logic [7:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = data;
    in_mode   = mode;
    in_amt    = amt;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL %s_in_ready got=%b exp=1", name, in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL %s_early_valid got=%b exp=0", name, out_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp)
      $display("FAIL %s got=%b/%h exp=1/%h", name, out_valid, out_data, exp);
    else n_pass++;
    tick();
  endtask

  task automatic test_rev_w2();
    bit got = 0;
    in_valid2 = 1'b1;
    in_data2  = 2'b01;
    in_mode2  = 2'd1;
    tick();
    in_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid2) begin
        got = 1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!got) $display("FAIL rev_w2 timeout waiting for out_valid");
    else if (out_data2 !== 2'b10) $display("FAIL rev_w2 got=%b exp=10", out_data2);
    else n_pass++;
    tick();
  endtask

  task automatic test_rotl_w6();
    bit got = 0;
    in_valid6 = 1'b1;
    in_data6  = 6'b100000;
    in_mode6  = 2'd2;
    in_amt6   = 3'd7;      // 7 mod 6 = 1
    tick();
    in_valid6 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid6) begin
        got = 1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!got) $display("FAIL rotl_w6 timeout waiting for out_valid");
    else if (out_data6 !== 6'b000001) $display("FAIL rotl_w6 got=%b exp=000001", out_data6);
    else n_pass++;
    tick();
  endtask

  // Five REV words on consecutive cycles must come out on consecutive
  // cycles, in order.
  task automatic test_back_to_back();
    logic [7:0] din  [5] = '{8'h01, 8'h02, 8'h0F, 8'h33, 8'hC1};
    logic [7:0] dexp [5] = '{8'h80, 8'h40, 8'hF0, 8'hCC, 8'h83};
    logic [7:0] e;
    int n_out = 0, first_cyc = -1, last_cyc = -1;
    exp_q.delete();
    out_ready = 1'b1;
    in_mode   = 2'd1;
    in_valid  = 1'b1;
    in_data   = din[0];
    exp_q.push_back(dexp[0]);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c < 5) begin
        in_data = din[c];
        exp_q.push_back(dexp[c]);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        n_out++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++;
        if (out_data !== e) $display("FAIL b2b_word%0d got=%h exp=%h", n_out, out_data, e);
        else n_pass++;
      end
    end
    n_checks++;
    if (n_out != 5 || last_cyc - first_cyc != 4)
      $display("FAIL b2b_throughput words=%0d span=%0d exp=5/4", n_out, last_cyc - first_cyc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_mode   = 2'd0;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    tick();
    in_data = 8'h02;
    tick();
    in_data = 8'h03;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full got=%b exp=0", in_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h01)
        $display("FAIL bp_hold%0d got=%b/%h exp=1/01", i, out_valid, out_data);
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_in_ready_comb got=%b exp=1", in_ready);
    else n_pass++;
    tick();   // drains 01, accepts 03
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h02)
      $display("FAIL bp_out2 got=%b/%h exp=1/02", out_valid, out_data);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h03)
      $display("FAIL bp_out3 got=%b/%h exp=1/03", out_valid, out_data);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty got=%b exp=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    out_ready = 1'b0;
    in_mode   = 2'd0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    tick();
    in_data = 8'hBB;
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00)
      $display("FAIL rst_mid got=%b/%h exp=0/00", out_valid, out_data);
    else n_pass++;
`ifdef BITPERM_PIPE_COUNT_EN
    n_checks++;
    if (count8 !== 16'd0) $display("FAIL rst_mid_count got=%0d exp=0", count8);
    else n_pass++;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    n_checks++;
    if (seen) $display("FAIL rst_mid_stale got=stale word exp=none");
    else n_pass++;
  endtask

`ifdef BITPERM_PIPE_COUNT_EN
  task automatic test_counter();
    out_ready = 1'b1;
    in_mode   = 2'd0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (count8 !== 16'd5) $display("FAIL count5 got=%0d exp=5", count8);
    else n_pass++;
    in_valid = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (count8 !== 16'hFFFF) $display("FAIL count_sat got=%h exp=ffff", count8);
    else n_pass++;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (count8 !== 16'hFFFF) $display("FAIL count_sat_hold got=%h exp=ffff", count8);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_mode8("rev",      8'h01, 2'd1, 3'd0, 8'h80);
    test_mode8("rotl",     8'h81, 2'd2, 3'd3, 8'h0C);
    test_mode8("pairswap", 8'hA5, 2'd3, 3'd0, 8'h5A);
    test_mode8("pass",     8'h3C, 2'd0, 3'd5, 8'h3C);
    test_mode8("rotl7",    8'h01, 2'd2, 3'd7, 8'h80);
    test_rev_w2();
    test_rotl_w6();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef BITPERM_PIPE_COUNT_EN
    test_counter();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
